mem_bus_ctrl: RTL

//  Registered, multi-cycle memory/MMIO bus controller between CPU load/store stage and board SRAM banks,

---
 rtl/mem_bus_pkg.sv | 40 ++++
 rtl/mem_lane_align.sv | 42 ++++
 rtl/mem_bus_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared encodings for the memory/MMIO bus controller.
// It holds the access-size codes, the FSM state enum, the MMIO register
// offsets, and the byte-lane helper functions.
package mem_bus_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [15:0] OFS_UART_DATA = 16'h03F8;
    localparam logic [15:0] OFS_UART_STAT = 16'h03FC;
    localparam logic [15:0] OFS_LED       = 16'h0400;
    localparam logic [15:0] OFS_DPY       = 16'h0408;

    // Byte lanes touched by an access of the given size, before the address shift.
    function automatic logic [3:0] lane_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 4'b0001;
            SZ_HALF: return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Halfwords need an even address and words need a 4-byte-aligned address.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] ofs);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return ofs[0];
            default: return ofs != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering.
// For stores it replicates the write data across the lanes and produces the
// active-low byte enables. For loads it selects a byte or halfword lane and
// applies sign or zero extension. It has no state, so a cache can reuse it.
module mem_lane_align
    import mem_bus_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  ofs_i,
    input  logic        sign_ext_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic [3:0]  be_n_o
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Lane enables, store replication and load select/extend
    always_comb begin
        be_n_o = ~(lane_mask(size_i) << ofs_i);
        rbyte  = rword_i[{ofs_i, 3'b000} +: 8];
        rhalf  = rword_i[{ofs_i[1], 4'b0000} +: 16];
        case (size_i)
            SZ_BYTE: begin
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{sign_ext_i & rbyte[7]}}, rbyte};
            end
            SZ_HALF: begin
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{sign_ext_i & rhalf[15]}}, rhalf};
            end
            default: begin
                wdata_o = wdata_i;
                rdata_o = rword_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: registered multi-cycle bus controller between the CPU
// load/store stage and the SRAM banks, the UART and the debug LED/DPY registers.
// Each access runs IDLE -> SETUP -> ACCESS (WAIT_CYCLES cycles) -> DONE.
// Faulting accesses skip ACCESS and raise no strobes.
// Optional feature: define MEM_BUS_UART_EN to map the UART data and status
// registers. When it is not defined, the UART strobes stay high and those
// offsets fault.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int          NUM_BANKS   = 2,
    parameter int          BANK_AW     = 20,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [15:0] MMIO_BASE   = 16'hBFD0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req,
    input  logic                         we,
    input  logic [31:0]                  addr,
    input  logic [1:0]                   size,
    input  logic                         sign_ext,
    input  logic [31:0]                  wdata,
    output logic [31:0]                  rdata,
    output logic                         ack,
    output logic                         fault,
    inout  wire  [NUM_BANKS*32-1:0]      sram_data,
    output logic [NUM_BANKS*BANK_AW-1:0] sram_addr,
    output logic [NUM_BANKS*4-1:0]       sram_be_n,
    output logic [NUM_BANKS-1:0]         sram_ce_n,
    output logic [NUM_BANKS-1:0]         sram_oe_n,
    output logic [NUM_BANKS-1:0]         sram_we_n,
    output logic                         uart_rdn,
    output logic                         uart_wrn,
    input  logic                         uart_dataready,
    input  logic                         uart_tbre,
    input  logic                         uart_tsre,
    output logic [15:0]                  debug_leds,
    output logic [7:0]                   debug_dpys
);

    localparam int         BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [2:0]  wait_q, wait_d;

    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q;
    logic        we_q, sext_q;

    logic [31:0] rdata_q;
    logic        ack_q, fault_q;
    logic [15:0] leds_q;
    logic [7:0]  dpys_q;

    logic [15:0]          ofs;
    logic                 is_mmio, misal, unmapped, acc_fault, sram_op;
    logic                 hit_udata, hit_ustat, hit_led, hit_dpy;
    logic [BANK_BITS-1:0] bank_sel;
    logic                 enter_done, in_access, drive_phase;
    logic [31:0]          wdata_rep, sram_word, load_ext, load_val;
    logic [3:0]           be_n;

    // Decode the latched request: target space, register hit, fault class
    always_comb begin
        ofs       = addr_q[15:0];
        is_mmio   = (addr_q[31:16] == MMIO_BASE);
        misal     = misaligned(size_q, addr_q[1:0]);
        hit_led   = is_mmio && (ofs == OFS_LED);
        hit_dpy   = is_mmio && (ofs == OFS_DPY);
`ifdef MEM_BUS_UART_EN
        hit_udata = is_mmio && (ofs == OFS_UART_DATA);
        hit_ustat = is_mmio && (ofs == OFS_UART_STAT);
`else
        hit_udata = 1'b0;
        hit_ustat = 1'b0;
`endif
        unmapped  = is_mmio && !(hit_udata || hit_ustat || hit_led || hit_dpy);
        acc_fault = misal || unmapped;
        sram_op   = !is_mmio && !acc_fault;
        bank_sel  = '0;
        if (NUM_BANKS > 1) begin
            bank_sel = addr_q[BANK_AW+2 +: BANK_BITS];
        end
    end

    mem_lane_align u_align (
        .size_i     (size_q),
        .ofs_i      (addr_q[1:0]),
        .sign_ext_i (sext_q),
        .wdata_i    (wdata_q),
        .rword_i    (sram_word),
        .wdata_o    (wdata_rep),
        .rdata_o    (load_ext),
        .be_n_o     (be_n)
    );

    assign sram_word = sram_data[{bank_sel, 5'b00000} +: 32];

    // FSM state and wait counter; reset forces IDLE, so all strobes drop at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wait_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic; req is only looked at in IDLE, so dropping it mid-access has no effect
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (acc_fault) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ACCESS;
                    wait_d  = WAIT_LAST;
                end
            end
            ST_ACCESS: begin
                if (wait_q == 3'd0) begin
                    state_d = ST_DONE;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Phase decode for strobes, store-bus drive and UART strobes
    always_comb begin
        in_access   = (state_q == ST_ACCESS);
        drive_phase = (state_q != ST_IDLE) && we_q && !acc_fault;
        uart_rdn    = 1'b1;
        uart_wrn    = 1'b1;
`ifdef MEM_BUS_UART_EN
        uart_rdn    = !(in_access && hit_udata && !we_q);
        uart_wrn    = !(in_access && hit_udata && we_q);
`endif
    end

    // Per-bank strobes, lane enables and the tri-stated store bus.
    // Bank 0 also carries UART write data.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic sel, drv;
        assign sel = sram_op && (bank_sel == BANK_BITS'(b));
        assign drv = drive_phase && (sel || ((b == 0) && hit_udata));
        assign sram_ce_n[b] = !(in_access && sel);
        assign sram_oe_n[b] = !(in_access && sel && !we_q);
        assign sram_we_n[b] = !(in_access && sel && we_q);
        assign sram_be_n[b*4 +: 4] = ((state_q != ST_IDLE) && sel) ? be_n : 4'hF;
        assign sram_addr[b*BANK_AW +: BANK_AW] = addr_q[BANK_AW+1:2];
        assign sram_data[b*32 +: 32] = drv ? wdata_rep : 32'bz;
    end

    // Load source selection: MMIO registers, UART, or the aligned SRAM lane
    always_comb begin
        if (hit_udata) begin
            load_val = {24'b0, sram_data[7:0]};
        end else if (hit_ustat) begin
            load_val = {30'b0, uart_dataready, uart_tbre & uart_tsre};
        end else if (hit_led) begin
            load_val = {16'b0, leds_q};
        end else if (hit_dpy) begin
            load_val = {24'b0, dpys_q};
        end else begin
            load_val = load_ext;
        end
    end

    assign enter_done = ((state_q == ST_SETUP) && acc_fault) ||
                        ((state_q == ST_ACCESS) && (wait_q == 3'd0));

    // Capture the request fields when an access is accepted
    always_ff @(posedge clk) begin
        if ((state_q == ST_IDLE) && req) begin
            addr_q  <= addr;
            we_q    <= we;
            size_q  <= size;
            sext_q  <= sign_ext;
            wdata_q <= wdata;
        end
    end

    // Completion: ack/fault pulse, load data capture and MMIO register update on entering DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q   <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= 32'd0;
            leds_q  <= 16'd0;
            dpys_q  <= 8'd0;
        end else begin
            ack_q   <= enter_done;
            fault_q <= enter_done && acc_fault;
            if (enter_done) begin
                if (acc_fault) begin
                    rdata_q <= 32'd0;
                end else if (!we_q) begin
                    rdata_q <= load_val;
                end else if (hit_led) begin
                    leds_q <= wdata_q[15:0];
                end else if (hit_dpy) begin
                    dpys_q <= wdata_q[7:0];
                end
            end
        end
    end

    assign rdata      = rdata_q;
    assign ack        = ack_q;
    assign fault      = fault_q;
    assign debug_leds = leds_q;
    assign debug_dpys = dpys_q;

endmodule
